// File: rtl/crash_detector_multi.sv
// -----------------------------------------------------------------------------
// crash_detector_multi
//
// Collision detector for the asteroid dodging game. One player lane mask is
// compared against NUM_OBJ object lane masks. All masks are active-low: a 0
// bit means that lane/segment is occupied. A collision produces a single
// crash strobe, costs one life and then opens an invulnerability (grace)
// window. After grace, the detector waits for the overlap to clear before it
// re-arms, so a lingering overlap never costs a second life.
//
// Ports
//   clk          in   1                  system clock, rising edge
//   rst          in   1                  synchronous reset, active-high
//   enable       in   1                  game running; gates detection and
//                                        the grace countdown
//   player_pos   in   WIDTH              player mask, active-low
//   object_pos   in   NUM_OBJ*WIDTH      object i at [i*WIDTH +: WIDTH]
//   display_out  out  WIDTH              AND of player and all object masks
//   crash_pulse  out  1                  one-cycle crash strobe
//   crash_obj    out  NUM_OBJ            objects involved in the last crash
//   lives_left   out  $clog2(LIVES+1)    remaining lives
//   grace_active out  1                  high while the grace window runs
//   game_over    out  1                  sticky once lives reach zero
//
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module crash_detector_multi #(
  parameter int               WIDTH        = 7,
  parameter int               NUM_OBJ      = 4,
  parameter logic [WIDTH-1:0] CHECK_MASK   = 7'b0111111,
  parameter int               LIVES        = 3,
  parameter int               GRACE_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           player_pos,
  input  logic [NUM_OBJ*WIDTH-1:0]   object_pos,
  output logic [WIDTH-1:0]           display_out,
  output logic                       crash_pulse,
  output logic [NUM_OBJ-1:0]         crash_obj,
  output logic [$clog2(LIVES+1)-1:0] lives_left,
  output logic                       grace_active,
  output logic                       game_over
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int LIVES_W = $clog2(LIVES + 1);
  // A zero-length grace still needs a one-bit counter to keep the code legal.
  localparam int CNT_W   = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ZERO = {LIVES_W{1'b0}};
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // The load value is one less than the window length because the cycle in
  // which the counter reads zero is itself the last grace cycle.
  localparam logic [CNT_W-1:0] GRACE_LOAD =
    CNT_W'((GRACE_CYCLES > 0) ? (GRACE_CYCLES - 1) : 0);

  localparam logic [WIDTH-1:0]   DISP_IDLE = {WIDTH{1'b1}};
  localparam logic [NUM_OBJ-1:0] OBJ_NONE  = {NUM_OBJ{1'b0}};

  // State encoding: five states need three bits.
  localparam logic [2:0] ST_NOCRASH = 3'd0;
  localparam logic [2:0] ST_CRASH   = 3'd1;
  localparam logic [2:0] ST_GRACE   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]         state_q,        state_d;
  logic [CNT_W-1:0]   grace_cnt_q,    grace_cnt_d;
  logic [WIDTH-1:0]   display_q,      display_d;
  logic               crash_pulse_q,  crash_pulse_d;
  logic [NUM_OBJ-1:0] crash_obj_q,    crash_obj_d;
  logic [LIVES_W-1:0] lives_q,        lives_d;
  logic               grace_active_q, grace_active_d;
  logic               game_over_q,    game_over_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [NUM_OBJ-1:0] overlap_s;
  logic               hit_s;
  logic [WIDTH-1:0]   display_and_s;
  logic [LIVES_W-1:0] lives_dec_s;

  // Per-object overlap: a lane occupied (0) in both masks and enabled in
  // CHECK_MASK is a collision. Also builds the merged display mask.
  always_comb begin
    overlap_s     = OBJ_NONE;
    display_and_s = player_pos;
    for (int i = 0; i < NUM_OBJ; i++) begin
      overlap_s[i]  = |(~player_pos & ~object_pos[i*WIDTH +: WIDTH] & CHECK_MASK);
      display_and_s = display_and_s & object_pos[i*WIDTH +: WIDTH];
    end
  end

  // Any-object collision flag.
  always_comb begin
    if (overlap_s != OBJ_NONE) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Saturating decrement so the lives counter can never wrap below zero.
  always_comb begin
    if (lives_q == LIVES_ZERO) begin
      lives_dec_s = LIVES_ZERO;
    end else begin
      lives_dec_s = lives_q - LIVES_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // Crash sequencing: detect, report one strobe, run grace, wait for the
  // overlap to clear, or park in OVER once all lives are gone.
  always_comb begin
    state_d        = state_q;
    grace_cnt_d    = grace_cnt_q;
    display_d      = display_and_s;
    crash_pulse_d  = 1'b0;
    crash_obj_d    = crash_obj_q;
    lives_d        = lives_q;
    grace_active_d = grace_active_q;
    game_over_d    = game_over_q;

    case (state_q)
      ST_NOCRASH: begin
        if (enable && hit_s) begin
          state_d     = ST_CRASH;
          crash_obj_d = overlap_s;
        end else begin
          state_d     = ST_NOCRASH;
        end
      end

      // Reported one cycle after detection; enable is not consulted here so
      // a detected crash is always accounted for.
      ST_CRASH: begin
        crash_pulse_d = 1'b1;
        lives_d       = lives_dec_s;
        if (lives_dec_s == LIVES_ZERO) begin
          state_d        = ST_OVER;
          game_over_d    = 1'b1;
          grace_active_d = 1'b0;
        end else if (GRACE_CYCLES > 0) begin
          state_d        = ST_GRACE;
          grace_cnt_d    = GRACE_LOAD;
          grace_active_d = 1'b1;
        end else begin
          state_d        = ST_WAIT;
        end
      end

      // Hits are ignored; the countdown only advances while the game runs.
      ST_GRACE: begin
        if (enable) begin
          if (grace_cnt_q == CNT_ZERO) begin
            state_d        = ST_WAIT;
            grace_active_d = 1'b0;
          end else begin
            grace_cnt_d    = grace_cnt_q - CNT_ONE;
          end
        end else begin
          grace_cnt_d = grace_cnt_q;
        end
      end

      // Re-arm only after a cycle with no overlap, regardless of enable.
      ST_WAIT: begin
        if (!hit_s) begin
          state_d = ST_NOCRASH;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_OVER: begin
        state_d        = ST_OVER;
        game_over_d    = 1'b1;
        lives_d        = LIVES_ZERO;
        grace_active_d = 1'b0;
      end

      // Illegal codes recover to NOCRASH and leave the status outputs alone.
      default: begin
        state_d       = ST_NOCRASH;
        crash_pulse_d = crash_pulse_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Synchronous reset has priority over every state, including GRACE and OVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_NOCRASH;
      grace_cnt_q    <= CNT_ZERO;
      display_q      <= DISP_IDLE;
      crash_pulse_q  <= 1'b0;
      crash_obj_q    <= OBJ_NONE;
      lives_q        <= LIVES_INIT;
      grace_active_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      grace_cnt_q    <= grace_cnt_d;
      display_q      <= display_d;
      crash_pulse_q  <= crash_pulse_d;
      crash_obj_q    <= crash_obj_d;
      lives_q        <= lives_d;
      grace_active_q <= grace_active_d;
      game_over_q    <= game_over_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign display_out  = display_q;
  assign crash_pulse  = crash_pulse_q;
  assign crash_obj    = crash_obj_q;
  assign lives_left   = lives_q;
  assign grace_active = grace_active_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_crash_detector_multi.sv
// -----------------------------------------------------------------------------
// tb_crash_detector_multi
//
// Bench for crash_detector_multi with WIDTH=7, NUM_OBJ=2, LIVES=2,
// GRACE_CYCLES=4. A directed vector table with hand-computed expectations,
// hand-written multi-cycle sequences, and a randomized run checked against a
// behavioural model of the game rules.
// -----------------------------------------------------------------------------
module tb_crash_detector_multi;

  localparam int WIDTH   = 7;
  localparam int NUM_OBJ = 2;
  localparam int LIVES   = 2;
  localparam int GRACE   = 4;

  localparam logic [6:0] FREE = 7'h7F;
  localparam logic [6:0] LN0  = 7'b1111110;
  localparam logic [6:0] LN6  = 7'b0111111;
  localparam logic [6:0] CMSK = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [6:0]  player_pos;
  logic [13:0] object_pos;
  logic [6:0]  display_out;
  logic        crash_pulse;
  logic [1:0]  crash_obj;
  logic [1:0]  lives_left;
  logic        grace_active;
  logic        game_over;

  crash_detector_multi #(
    .WIDTH        (WIDTH),
    .NUM_OBJ      (NUM_OBJ),
    .CHECK_MASK   (CMSK),
    .LIVES        (LIVES),
    .GRACE_CYCLES (GRACE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .player_pos   (player_pos),
    .object_pos   (object_pos),
    .display_out  (display_out),
    .crash_pulse  (crash_pulse),
    .crash_obj    (crash_obj),
    .lives_left   (lives_left),
    .grace_active (grace_active),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the game rules (not cycle-state encoded)
  // ---------------------------------------------------------------------------
  int         m_lives;
  bit         m_over;
  bit         m_pending;    // collision seen, to be reported on next edge
  bit         m_wait;       // must see a clear cycle before re-arming
  int         m_grace_left; // enabled cycles of invulnerability still owed
  logic [6:0] m_disp;
  logic       m_pulse;
  logic [1:0] m_obj;

  task automatic model_edge(input logic r, input logic en,
                            input logic [6:0] p, input logic [6:0] o0, input logic [6:0] o1);
    logic [1:0] ov;
    logic       hit;
    if (r) begin
      m_lives = LIVES; m_over = 0; m_pending = 0; m_wait = 0;
      m_grace_left = 0; m_disp = FREE; m_pulse = 0; m_obj = 2'b00;
    end else begin
      ov[0] = ((~p & ~o0 & CMSK) != 7'd0);
      ov[1] = ((~p & ~o1 & CMSK) != 7'd0);
      hit   = (ov != 2'b00);
      m_disp  = p & o0 & o1;
      m_pulse = 0;
      if (m_over) begin
        m_lives = 0;
      end else if (m_pending) begin
        m_pending = 0;
        m_pulse   = 1;
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_over = 1;
        else if (GRACE > 0) m_grace_left = GRACE;
        else m_wait = 1;
      end else if (m_grace_left > 0) begin
        if (en) begin
          m_grace_left--;
          if (m_grace_left == 0) m_wait = 1;
        end
      end else if (m_wait) begin
        if (!hit) m_wait = 0;
      end else if (en && hit) begin
        m_pending = 1;
        m_obj     = ov;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".display"}, display_out,  m_disp);
    check({tag, ".pulse"},   crash_pulse,  m_pulse);
    check({tag, ".obj"},     crash_obj,    m_obj);
    check({tag, ".lives"},   lives_left,   m_lives);
    check({tag, ".grace"},   grace_active, (m_grace_left > 0) ? 1 : 0);
    check({tag, ".over"},    game_over,    m_over);
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [6:0] p, input logic [6:0] o0, input logic [6:0] o1);
    rst = r; enable = en; player_pos = p; object_pos = {o1, o0};
    @(posedge clk);
    model_edge(r, en, p, o0, o1);
    #1;
    compare_all(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       r;
    logic       en;
    logic [6:0] p;
    logic [6:0] o0;
    logic [6:0] o1;
    logic [6:0] disp;
    logic       pulse;
    logic [1:0] obj;
    logic [1:0] lives;
    logic       grace;
    logic       over;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic en, input logic [6:0] p,
                              input logic [6:0] o0, input logic [6:0] o1,
                              input logic [6:0] disp, input logic pulse, input logic [1:0] obj,
                              input logic [1:0] lives, input logic grace, input logic over);
    vec_t v;
    v.r = r; v.en = en; v.p = p; v.o0 = o0; v.o1 = o1;
    v.disp = disp; v.pulse = pulse; v.obj = obj; v.lives = lives;
    v.grace = grace; v.over = over;
    return v;
  endfunction

  function automatic logic [6:0] lane(input int k);
    logic [6:0] one;
    one = 7'b0000001;
    return ~(one << k);
  endfunction

  vec_t tbl[14];
  int   pulse_cnt;
  int   grace_cnt;

  initial begin
    rst = 1'b1; enable = 1'b1; player_pos = FREE; object_pos = {FREE, FREE};

    //           rst  en  player obj0  obj1   disp   pls  obj    lv     gr    ov
    tbl[0]  = mk(1'b1,1'b1,FREE, FREE, FREE, 7'h7F, 1'b0,2'b00,2'd2,1'b0,1'b0);
    tbl[1]  = mk(1'b1,1'b1,FREE, FREE, FREE, 7'h7F, 1'b0,2'b00,2'd2,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b1,LN6,  LN6,  FREE, LN6,   1'b0,2'b00,2'd2,1'b0,1'b0);
    tbl[3]  = mk(1'b0,1'b1,LN6,  LN6,  FREE, LN6,   1'b0,2'b00,2'd2,1'b0,1'b0);
    tbl[4]  = mk(1'b0,1'b1,LN0,  LN0,  FREE, LN0,   1'b0,2'b01,2'd2,1'b0,1'b0);
    tbl[5]  = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b1,2'b01,2'd1,1'b1,1'b0);
    tbl[6]  = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b0,2'b01,2'd1,1'b1,1'b0);
    tbl[7]  = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b0,2'b01,2'd1,1'b1,1'b0);
    tbl[8]  = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b0,2'b01,2'd1,1'b1,1'b0);
    tbl[9]  = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b0,2'b01,2'd1,1'b0,1'b0);
    tbl[10] = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b0,2'b01,2'd1,1'b0,1'b0);
    tbl[11] = mk(1'b0,1'b1,LN0,  LN0,  LN0,  LN0,   1'b0,2'b11,2'd1,1'b0,1'b0);
    tbl[12] = mk(1'b0,1'b1,LN0,  FREE, FREE, LN0,   1'b1,2'b11,2'd0,1'b0,1'b1);
    tbl[13] = mk(1'b0,1'b1,LN0,  LN0,  FREE, LN0,   1'b0,2'b11,2'd0,1'b0,1'b1);

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].r; enable = tbl[i].en;
      player_pos = tbl[i].p; object_pos = {tbl[i].o1, tbl[i].o0};
      @(posedge clk);
      model_edge(tbl[i].r, tbl[i].en, tbl[i].p, tbl[i].o0, tbl[i].o1);
      #1;
      check($sformatf("vec%0d.display", i), display_out,  tbl[i].disp);
      check($sformatf("vec%0d.pulse", i),   crash_pulse,  tbl[i].pulse);
      check($sformatf("vec%0d.obj", i),     crash_obj,    tbl[i].obj);
      check($sformatf("vec%0d.lives", i),   lives_left,   tbl[i].lives);
      check($sformatf("vec%0d.grace", i),   grace_active, tbl[i].grace);
      check($sformatf("vec%0d.over", i),    game_over,    tbl[i].over);
    end

    // Persisting overlap through grace and WAIT: exactly one life lost.
    step("hold.rst", 1'b1, 1'b1, FREE, FREE, FREE);
    step("hold.rst", 1'b1, 1'b1, FREE, FREE, FREE);
    pulse_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step("hold.hit", 1'b0, 1'b1, LN0, LN0, FREE);
      if (crash_pulse) pulse_cnt++;
    end
    check("hold.pulse_count", pulse_cnt, 1);
    check("hold.lives", lives_left, 2'd1);
    step("hold.clear", 1'b0, 1'b1, LN0, FREE, FREE);
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step("hold.rehit", 1'b0, 1'b1, LN0, LN0, FREE);
      if (crash_pulse) pulse_cnt++;
    end
    check("rehit.pulse_count", pulse_cnt, 1);
    check("rehit.lives", lives_left, 2'd0);
    check("rehit.over", game_over, 1'b1);
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step("over.hit", 1'b0, 1'b1, LN0, FREE, FREE);
      step("over.hit", 1'b0, 1'b1, LN0, LN0, LN0);
      if (crash_pulse) pulse_cnt++;
    end
    check("over.pulse_count", pulse_cnt, 0);

    // Reset from OVER.
    step("over.rst", 1'b1, 1'b1, LN0, LN0, FREE);
    check("over.rst.lives", lives_left, 2'd2);
    check("over.rst.over", game_over, 1'b0);

    // Grace stretches by the number of disabled cycles.
    step("str.idle", 1'b0, 1'b1, FREE, FREE, FREE);
    step("str.hit", 1'b0, 1'b1, LN0, FREE, LN0);
    step("str.pulse", 1'b0, 1'b1, LN0, FREE, FREE);
    grace_cnt = grace_active ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      step("str.run", 1'b0, (i >= 1 && i <= 3) ? 1'b0 : 1'b1, LN0, FREE, FREE);
      if (grace_active) grace_cnt++;
    end
    check("stretch.grace_len", grace_cnt, 7);
    check("stretch.obj", crash_obj, 2'b10);

    // Reset in the middle of grace.
    step("mid.rst", 1'b1, 1'b1, FREE, FREE, FREE);
    step("mid.hit", 1'b0, 1'b1, LN0, LN0, FREE);
    step("mid.pulse", 1'b0, 1'b1, FREE, FREE, FREE);
    step("mid.grace", 1'b0, 1'b1, FREE, FREE, FREE);
    check("mid.grace_on", grace_active, 1'b1);
    step("mid.rst", 1'b1, 1'b1, FREE, FREE, FREE);
    check("mid.rst.lives", lives_left, 2'd2);
    check("mid.rst.grace", grace_active, 1'b0);
    check("mid.rst.display", display_out, 7'h7F);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic       en;
      logic [6:0] p;
      logic [6:0] o0;
      logic [6:0] o1;
      int         k;
      r  = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 9) != 0);
      k  = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) p = 7'($urandom);
      else p = lane(k);
      case ($urandom_range(0, 2))
        0: o0 = FREE;
        1: o0 = p;
        default: o0 = lane($urandom_range(0, 6));
      endcase
      case ($urandom_range(0, 2))
        0: o1 = FREE;
        1: o1 = p;
        default: o1 = lane($urandom_range(0, 6));
      endcase
      step($sformatf("rand%0d", i), r, en, p, o0, o1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
